// File: rtl/mcs4_pkg.sv
// MCS-4 shared types: bus nibble/byte/address, instruction-cycle phases,
// fetch state encoding, and two-word opcode decoding.
package mcs4;

  localparam int unsigned CHAR_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CYC_W  = 3;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Bus phase within one 8-clk instruction cycle
  typedef enum logic [CYC_W-1:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } instr_cyc_t;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } fetch_state_t;

  // Instruction handed to execute
  typedef struct packed {
    char_t opr;
    char_t opa;
    byte_t word2;
    logic  two_word;
  } instr_t;

  localparam char_t OPR_JCN = 4'h1;
  localparam char_t OPR_FIM = 4'h2;
  localparam char_t OPR_JUN = 4'h4;
  localparam char_t OPR_JMS = 4'h5;
  localparam char_t OPR_ISZ = 4'h7;

  // FIM shares OPR 0x2 with SRC; only the even OPA form carries a data word
  function automatic logic is_two_word(char_t opr, char_t opa);
    logic r;
    r = 1'b0;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: r = 1'b1;
      OPR_FIM:                            r = ~opa[0];
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i4004_fetch_if.sv
// MCS-4 fetch bundle: ROM bus signals, phase/pc status, instruction hand-off
// to execute and the redirect path back from execute.
//   master : i4004 fetch stage
//   slave  : ROMs / execute stage
interface i4004_fetch_if;
  import mcs4::*;

  logic       sync;
  logic       cm_rom;
  char_t      dbus_in;
  char_t      dbus_out;
  logic       dbus_oe;
  instr_cyc_t icyc;
  addr_t      pc;
  logic       instr_valid;
  char_t      instr_opr;
  char_t      instr_opa;
  byte_t      instr_word2;
  logic       instr_two_word;
  logic       jmp_en;
  addr_t      jmp_addr;

  modport master (
    output sync, cm_rom, dbus_out, dbus_oe, icyc, pc,
    output instr_valid, instr_opr, instr_opa, instr_word2, instr_two_word,
    input  dbus_in, jmp_en, jmp_addr
  );

  modport slave (
    input  sync, cm_rom, dbus_out, dbus_oe, icyc, pc,
    input  instr_valid, instr_opr, instr_opa, instr_word2, instr_two_word,
    output dbus_in, jmp_en, jmp_addr
  );

endinterface

// File: rtl/i4004_timing.sv
// Free-running 8-phase instruction-cycle generator.
// Ports: clk, rst (async, active-high); icyc current phase; sync high in X3;
// cm_rom high in A3; dbus_oe high in A1..A3. Strobes decode the phase register.
module i4004_timing
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst,
  output instr_cyc_t icyc,
  output logic       sync,
  output logic       cm_rom,
  output logic       dbus_oe
);

  logic [CYC_W-1:0] phase;

  // Reset parks in X3 so the first clk after release lands on A1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= CYC_W'(CYC_X3);
    end else begin
      phase <= CYC_W'(phase + CYC_W'(1));
    end
  end

  assign icyc    = instr_cyc_t'(phase);
  assign sync    = (icyc == CYC_X3);
  assign cm_rom  = (icyc == CYC_A3);
  assign dbus_oe = (phase < CYC_W'(CYC_M1));

endmodule

// File: rtl/i4004_fetch.sv
// i4004 fetch stage and MCS-4 bus master.
// Ports: clk, rst (async, active-high); bus (i4004_fetch_if.master) carrying
// sync/cm_rom/dbus_*, icyc, pc, the instr_* hand-off and jmp_en/jmp_addr.
// Drives pc nibbles in A1..A3, captures OPR/OPA in M1/M2, assembles one- or
// two-word instructions and presents them with a one-clk instr_valid in X1.
module i4004_fetch
  import mcs4::*;
#(
  parameter addr_t RESET_PC = 12'h000
) (
  input logic           clk,
  input logic           rst,
  i4004_fetch_if.master bus
);

  instr_cyc_t   cyc;
  fetch_state_t state_q;
  fetch_state_t state_d;
  addr_t        pc_q;
  char_t        hi_q;
  char_t        first_opr_q;
  char_t        first_opa_q;
  instr_t       instr_q;
  logic         valid_q;
  logic         end_m1;
  logic         end_m2;
  logic         instr_done_c;
  logic         jmp_take_c;

  i4004_timing u_timing (
    .clk     (clk),
    .rst     (rst),
    .icyc    (cyc),
    .sync    (bus.sync),
    .cm_rom  (bus.cm_rom),
    .dbus_oe (bus.dbus_oe)
  );

  // Address nibble for the current bus phase
  always_comb begin
    bus.dbus_out = '0;
    case (cyc)
      CYC_A1:  bus.dbus_out = pc_q[3:0];
      CYC_A2:  bus.dbus_out = pc_q[7:4];
      CYC_A3:  bus.dbus_out = pc_q[11:8];
      default: bus.dbus_out = '0;
    endcase
  end

  // Fetch FSM next state and completion/redirect strobes
  always_comb begin
    state_d      = state_q;
    end_m1       = (cyc == CYC_M1);
    end_m2       = (cyc == CYC_M2);
    instr_done_c = 1'b0;
    jmp_take_c   = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (end_m2) begin
          if (is_two_word(hi_q, bus.dbus_in)) begin
            state_d = ST_SECOND;
          end else begin
            instr_done_c = 1'b1;
          end
        end
        // Redirects are only honoured between instructions
        jmp_take_c = (cyc == CYC_X3) && bus.jmp_en;
      end
      ST_SECOND: begin
        if (end_m2) begin
          instr_done_c = 1'b1;
          state_d      = ST_FIRST;
        end
      end
      default: state_d = ST_FIRST;
    endcase
  end

  // Fetch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, nibble capture and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      hi_q        <= '0;
      first_opr_q <= '0;
      first_opa_q <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      // Set at the end of M2, so it is high for exactly the X1 clk
      valid_q <= instr_done_c;
      if (end_m1) begin
        hi_q <= bus.dbus_in;
      end
      if (end_m2) begin
        pc_q <= pc_q + ADDR_W'(1);
        if (state_q == ST_FIRST) begin
          first_opr_q <= hi_q;
          first_opa_q <= bus.dbus_in;
        end
      end
      if (instr_done_c) begin
        if (state_q == ST_FIRST) begin
          instr_q <= '{opr: hi_q, opa: bus.dbus_in, word2: '0, two_word: 1'b0};
        end else begin
          instr_q <= '{opr: first_opr_q, opa: first_opa_q,
                       word2: {hi_q, bus.dbus_in}, two_word: 1'b1};
        end
      end
      if (jmp_take_c) begin
        pc_q <= bus.jmp_addr;
      end
    end
  end

  assign bus.icyc           = cyc;
  assign bus.pc             = pc_q;
  assign bus.instr_valid    = valid_q;
  assign bus.instr_opr      = instr_q.opr;
  assign bus.instr_opa      = instr_q.opa;
  assign bus.instr_word2    = instr_q.word2;
  assign bus.instr_two_word = instr_q.two_word;

endmodule
